// File: rtl/spi_master_mc.sv
// Multi-channel SPI master (mode 0): serialises op/addr/data frames to one of
// NUM_CS slaves, with address/channel range checks and a read start-bit timeout.
module spi_master_mc #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 32,
  parameter int NUM_CS    = 4,
  parameter int CSW       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  parameter int CLK_DIV   = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [CSW-1:0]    req_cs,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_din,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_dout,
  output logic              rsp_err,
  output logic [1:0]        rsp_code,
  output logic              busy,
  output logic              sclk,
  output logic [NUM_CS-1:0] cs_n,
  output logic              mosi,
  input  logic              miso
);
  localparam int NBITS_W = 1 + ADDR_W + DATA_W;
  localparam int NBITS_R = 1 + ADDR_W;
  localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W   = $clog2(NBITS_W + 1);
  localparam int TO_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SETUP, S_SHIFT_TX, S_WAIT_START, S_SHIFT_RX, S_HOLD, S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [TO_W-1:0]     rise_q, rise_d;
  logic                wr_q, wr_d;
  logic [CSW-1:0]      cs_q, cs_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NBITS_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [1:0]          code_q, code_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_dout_q, rsp_dout_d;
  logic                rsp_err_q, rsp_err_d;
  logic [1:0]          rsp_code_q, rsp_code_d;
  logic                timed, tick;
  logic [BIT_W-1:0]    last_bit;

  always_comb begin
    timed = (state_q == S_SETUP) || (state_q == S_SHIFT_TX) || (state_q == S_WAIT_START) ||
            (state_q == S_SHIFT_RX) || (state_q == S_HOLD);
    tick  = timed && (cnt_q == CNT_W'(CLK_DIV - 1));
    last_bit = wr_q ? BIT_W'(NBITS_W - 1) : BIT_W'(NBITS_R - 1);
  end

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    rise_d      = rise_q;
    wr_d        = wr_q;
    cs_d        = cs_q;
    addr_d      = addr_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    code_d      = code_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cs_n_d      = cs_n_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dout_d  = rsp_dout_q;
    rsp_err_d   = rsp_err_q;
    rsp_code_d  = rsp_code_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          wr_d    = req_wr;
          cs_d    = req_cs;
          addr_d  = req_addr;
          tx_d    = {req_din, req_addr, req_wr};
          rx_d    = '0;
          code_d  = 2'b00;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // Channel check wins over address check.
        if (int'(cs_q) >= NUM_CS) begin
          code_d  = 2'b10;
          state_d = S_RESP;
        end else if (int'(addr_q) >= MEM_DEPTH) begin
          code_d  = 2'b01;
          state_d = S_RESP;
        end else begin
          for (int i = 0; i < NUM_CS; i++) cs_n_d[i] = (int'(cs_q) != i);
          mosi_d  = tx_q[0];
          bit_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tick) state_d = S_SHIFT_TX;
      end
      S_SHIFT_TX: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: present the next frame bit while sclk is low.
            sclk_d = 1'b0;
            if (bit_q == last_bit) begin
              mosi_d  = 1'b0;
              bit_d   = '0;
              rise_d  = '0;
              state_d = wr_q ? S_HOLD : S_WAIT_START;
            end else begin
              bit_d  = bit_q + 1'b1;
              tx_d   = tx_q >> 1;
              mosi_d = tx_q[1];
            end
          end
        end
      end
      S_WAIT_START: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            if (miso) begin
              bit_d   = '0;
              state_d = S_SHIFT_RX;
            end else begin
              rise_d = rise_q + 1'b1;
            end
          end else begin
            sclk_d = 1'b0;
            if (rise_q == TO_W'(TIMEOUT)) begin
              code_d  = 2'b11;
              state_d = S_HOLD;
            end
          end
        end
      end
      S_SHIFT_RX: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {miso, rx_q[DATA_W-1:1]};
            bit_d  = bit_q + 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BIT_W'(DATA_W)) state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          cs_n_d  = '1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        // Response registers load one cycle after entry and hold until taken.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = (code_q != 2'b00);
          rsp_code_d  = code_q;
          rsp_dout_d  = (code_q == 2'b00 && !wr_q) ? rx_q : '0;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_code_d  = 2'b00;
          rsp_dout_d  = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cnt_d       = (!timed || tick || (state_d != state_q)) ? '0 : cnt_q + 1'b1;
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      rise_q      <= '0;
      wr_q        <= 1'b0;
      cs_q        <= '0;
      addr_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      code_q      <= 2'b00;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      cs_n_q      <= '1;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dout_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      rise_q      <= rise_d;
      wr_q        <= wr_d;
      cs_q        <= cs_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      code_q      <= code_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      cs_n_q      <= cs_n_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dout_q  <= rsp_dout_d;
      rsp_err_q   <= rsp_err_d;
      rsp_code_q  <= rsp_code_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dout  = rsp_dout_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_code  = rsp_code_q;
  assign busy      = (state_q != S_IDLE);
  assign sclk      = sclk_q;
  assign cs_n      = cs_n_q;
  assign mosi      = mosi_q;
endmodule

// File: tb/tb_spi_master_mc.sv
// Scoreboard bench for spi_master_mc: default instance plus a NUM_CS=3 instance
// for the channel-range error, with a simple SPI slave model on miso.
module tb_spi_master_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req_valid = 1'b0, req_valid2 = 1'b0, req_wr = 1'b0, rsp_ready = 1'b1;
  logic [1:0] req_cs = '0;
  logic [7:0] req_addr = '0, req_din = '0;
  logic       miso;
  logic       req_ready, rsp_valid, rsp_err, busy, sclk, mosi;
  logic [7:0] rsp_dout;
  logic [1:0] rsp_code;
  logic [3:0] cs_n;
  logic       req_ready2, rsp_valid2, rsp_err2, busy2, sclk2, mosi2;
  logic [7:0] rsp_dout2;
  logic [1:0] rsp_code2;
  logic [2:0] cs_n2;

  spi_master_mc dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_cs(req_cs), .req_addr(req_addr), .req_din(req_din), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_dout(rsp_dout), .rsp_err(rsp_err), .rsp_code(rsp_code),
    .busy(busy), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  spi_master_mc #(.NUM_CS(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2), .req_wr(req_wr),
    .req_cs(req_cs), .req_addr(req_addr), .req_din(req_din), .rsp_valid(rsp_valid2),
    .rsp_ready(rsp_ready), .rsp_dout(rsp_dout2), .rsp_err(rsp_err2), .rsp_code(rsp_code2),
    .busy(busy2), .sclk(sclk2), .cs_n(cs_n2), .mosi(mosi2), .miso(miso)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask

  // Slave model: counts sclk rises, records mosi, and answers reads.
  int         rises = 0, rises2 = 0, csn_bad = 0, cs_low_cyc = 0, rise0 = 0, miso_mode = 0;
  logic [63:0] mosi_hist = '0;
  logic [3:0] exp_csn = '1;
  logic [7:0] slv_data = 8'h5C;
  int         nxt;
  always @(posedge sclk) begin
    rises++;
    mosi_hist = {mosi_hist[62:0], mosi};
    if (cs_n !== exp_csn) csn_bad++;
  end
  always @(posedge sclk2) rises2++;
  always @(negedge clk) if (cs_n !== 4'hF || cs_n2 !== 3'h7) cs_low_cyc++;
  // Start bit on the 4th rise after the 9-bit read header, then data LSB-first.
  assign nxt  = rises - rise0 + 1;
  assign miso = (miso_mode == 1) && ((nxt == 13) || (nxt >= 14 && nxt <= 21 && slv_data[nxt-14]));

  typedef struct {
    int         dut;
    logic [7:0] dout;
    logic [1:0] code;
    int         lat;
    int         acc;
  } exp_t;
  exp_t sbq[$];

  logic       vv[2];
  logic [7:0] dd[2];
  logic       ee[2];
  logic [1:0] cc[2];
  logic       ch[2];
  assign vv[0] = rsp_valid;  assign vv[1] = rsp_valid2;
  assign dd[0] = rsp_dout;   assign dd[1] = rsp_dout2;
  assign ee[0] = rsp_err;    assign ee[1] = rsp_err2;
  assign cc[0] = rsp_code;   assign cc[1] = rsp_code2;
  assign ch[0] = (cs_n == 4'hF);
  assign ch[1] = (cs_n2 == 3'h7);

  int   first_cyc[2];
  bit   in_rsp[2];
  exp_t em;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        in_rsp[d] = 1'b0;
      end else begin
        if (vv[d] && !in_rsp[d]) begin
          in_rsp[d]    = 1'b1;
          first_cyc[d] = cyc;
        end
        if (vv[d] && rsp_ready) begin
          in_rsp[d] = 1'b0;
          if (sbq.size() == 0) begin
            chk("unexpected_rsp", 64'(d), 64'hFF);
          end else begin
            em = sbq.pop_front();
            chk("rsp_source", 64'(d), 64'(em.dut));
            chk("rsp_dout", dd[d], em.dout);
            chk("rsp_code", cc[d], em.code);
            chk("rsp_err", ee[d], em.code != 2'b00);
            chk("csn_high_in_rsp", ch[d], 1);
            if (em.lat > 0) chk("rsp_latency", 64'(first_cyc[d] - em.acc), 64'(em.lat));
          end
        end
      end
    end
  end

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int d, input logic wr, input logic [1:0] cs, input logic [7:0] addr,
                       input logic [7:0] din, input logic [7:0] edout, input logic [1:0] ecode,
                       input int lat, input bit want_rsp, output int acc);
    exp_t e;
    int   n = 0;
    req_wr = wr; req_cs = cs; req_addr = addr; req_din = din;
    if (d == 0) req_valid = 1'b1; else req_valid2 = 1'b1;
    while (((d == 0) ? req_ready : req_ready2) !== 1'b1 && n < 300) begin
      tick1();
      n++;
    end
    if (n >= 300) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0; req_valid2 = 1'b0; acc = cyc;
      return;
    end
    tick1();
    acc = cyc;
    req_valid = 1'b0; req_valid2 = 1'b0;
    if (want_rsp) begin
      e.dut = d; e.dout = edout; e.code = ecode; e.lat = lat; e.acc = acc;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while ((sbq.size() != 0 || rsp_valid || rsp_valid2) && n < maxc) begin
      tick1();
      n++;
    end
    if (sbq.size() != 0 || rsp_valid || rsp_valid2) begin
      chk("rsp_wait_timeout", 0, 1);
      sbq.delete();
    end
    tick1();
  endtask

  initial begin
    #200us;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  int acc, acc2, r0, c0, h, bad;
  logic [7:0] snap;
  initial begin
    rst = 1'b1;
    repeat (3) tick1();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_cs_n", cs_n, 4'hF);
    chk("rst_mosi", mosi, 0);
    chk("rst_rsp_code", {rsp_err, rsp_code, rsp_dout}, 0);
    rst = 1'b0;
    tick1();
    chk("req_ready_after_rst", req_ready, 1);

    // 1: write cs=1 addr=0x05 din=0xA3
    exp_csn = 4'b1101; rise0 = rises; r0 = rises; c0 = csn_bad; miso_mode = 0;
    issue(0, 1'b1, 2'd1, 8'h05, 8'hA3, 8'h00, 2'b00, 74, 1'b1, acc);
    wait_done(300);
    chk("t1_rises", 64'(rises - r0), 17);
    chk("t1_mosi_bits", mosi_hist[16:0], 17'b11010000011000101);
    chk("t1_csn_frame", 64'(csn_bad - c0), 0);

    // 2: read cs=0 addr=0x1F, slave returns 0x5C after 3 idle periods
    exp_csn = 4'b1110; rise0 = rises; r0 = rises; c0 = csn_bad; miso_mode = 1;
    issue(0, 1'b0, 2'd0, 8'h1F, 8'h00, 8'h5C, 2'b00, 0, 1'b1, acc);
    wait_done(400);
    miso_mode = 0;
    chk("t2_rises", 64'(rises - r0), 21);
    chk("t2_csn_frame", 64'(csn_bad - c0), 0);

    // 3: address and channel range errors
    r0 = rises; c0 = cs_low_cyc;
    issue(0, 1'b0, 2'd2, 8'h20, 8'h00, 8'h00, 2'b01, 2, 1'b1, acc);
    wait_done(50);
    issue(1, 1'b0, 2'd3, 8'h01, 8'h00, 8'h00, 2'b10, 2, 1'b1, acc);
    wait_done(50);
    issue(1, 1'b1, 2'd3, 8'h20, 8'h11, 8'h00, 2'b10, 2, 1'b1, acc);
    wait_done(50);
    chk("t3_no_sclk", 64'(rises - r0 + rises2), 0);
    chk("t3_no_cs", 64'(cs_low_cyc - c0), 0);

    // 4: read timeout with miso held low
    exp_csn = 4'b0111; rise0 = rises; r0 = rises; miso_mode = 0;
    issue(0, 1'b0, 2'd3, 8'h00, 8'h00, 8'h00, 2'b11, 0, 1'b1, acc);
    wait_done(1000);
    chk("t4_rises", 64'(rises - r0), 73);

    // 5: stalled response, then a queued request
    exp_csn = 4'b1101; rise0 = rises; miso_mode = 1; rsp_ready = 1'b0;
    issue(0, 1'b0, 2'd1, 8'h03, 8'h00, 8'h5C, 2'b00, 0, 1'b1, acc);
    bad = 0;
    while (!rsp_valid && bad < 400) begin tick1(); bad++; end
    chk("t5_rsp_seen", rsp_valid, 1);
    snap = rsp_dout;
    chk("t5_snap_dout", snap, 8'h5C);
    for (int i = 0; i < 10; i++) begin
      tick1();
      chk("t5_valid_held", rsp_valid, 1);
      chk("t5_dout_held", rsp_dout, snap);
      chk("t5_req_ready_low", {req_ready, busy}, 2'b01);
    end
    miso_mode = 0; exp_csn = 4'b1110; rise0 = rises; r0 = rises;
    rsp_ready = 1'b1; h = cyc;
    issue(0, 1'b1, 2'd0, 8'h01, 8'h5A, 8'h00, 2'b00, 74, 1'b1, acc2);
    chk("t5_accept_gap", 64'(acc2 - h), 2);
    wait_done(300);
    chk("t5_rises", 64'(rises - r0), 17);

    // 6: reset at the 8th sclk rise of a write
    exp_csn = 4'b1110; rise0 = rises; r0 = rises;
    issue(0, 1'b1, 2'd0, 8'h07, 8'hFF, 8'h00, 2'b00, 0, 1'b0, acc);
    bad = 0;
    while ((rises - r0) < 8 && bad < 200) begin tick1(); bad++; end
    chk("t6_reached_rise8", 64'(rises - r0), 8);
    rst = 1'b1;
    tick1();
    chk("t6_cs_n", cs_n, 4'hF);
    chk("t6_sclk_rsp", {sclk, rsp_valid, busy}, 3'b000);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick1();
      if (rsp_valid) bad++;
    end
    chk("t6_no_rsp", 64'(bad), 0);
    exp_csn = 4'b1011; rise0 = rises; r0 = rises; c0 = csn_bad;
    issue(0, 1'b1, 2'd2, 8'h1E, 8'h81, 8'h00, 2'b00, 74, 1'b1, acc);
    wait_done(300);
    chk("t6_rises", 64'(rises - r0), 17);
    chk("t6_mosi_bits", mosi_hist[16:0], 17'b10111100010000001);
    chk("t6_csn_frame", 64'(csn_bad - c0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_master_mc.md
Name: spi_master_mc

Overview:
Parametrised multi-channel SPI master for the SPI memory subsystem. Serialises write/read transactions to one of NUM_CS slave memories over a divided SPI clock in mode 0. Adds address/channel range checking and a read-response timeout. Sits between the host request/response handshake and the SPI pins.

Parameters:
ADDR_W, 8, address field width in bits
DATA_W, 8, data field width in bits
MEM_DEPTH, 32, legal address range per slave, 0..MEM_DEPTH-1
NUM_CS, 4, number of slave chip selects
CSW, max(1,$clog2(NUM_CS)), width of the channel select field
CLK_DIV, 2, clk cycles per sclk half-period; must be >=1
TIMEOUT, 64, maximum sclk periods to wait for the read start bit

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready
req_wr  in  1  1=write, 0=read
req_cs  in  CSW  target slave index
req_addr  in  ADDR_W  memory address
req_din  in  DATA_W  write data
rsp_valid  out  1  response present; held until rsp_ready
rsp_ready  in  1  host consumes response
rsp_dout  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  error flag
rsp_code  out  2  00 ok, 01 addr>=MEM_DEPTH, 10 req_cs>=NUM_CS, 11 read timeout
busy  out  1  high in every state except IDLE
sclk  out  1  SPI clock, idle low
cs_n  out  NUM_CS  active-low selects, one-hot-low or all high
mosi  out  1  serial data to slave
miso  in  1  serial data from slave

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_dout=0, rsp_err=0, rsp_code=00, busy=0, sclk=0, cs_n=all 1, mosi=0. State=IDLE. req_ready rises the cycle after reset deasserts.
- Reset mid-transaction aborts immediately with the reset values above. No response is produced. The request is lost.
- Half-period tick: a counter runs 0..CLK_DIV-1 in SETUP, SHIFT_TX, WAIT_START, SHIFT_RX and HOLD. It clears on state entry. A tick is generated when the counter reaches CLK_DIV-1.
- The SPI format is mode 0. mosi changes only while sclk is low. The slave samples on sclk rising. The master samples miso on sclk rising.
- IDLE: req_ready=1. On valid&ready, capture wr/cs/addr/din and go to CHECK.
- CHECK (1 cycle):
  - If cs>=NUM_CS, set code 10 and go to RESP.
  - Else if addr>=MEM_DEPTH, set code 01 and go to RESP.
  - Else drive cs_n[cs]=0, mosi=op bit, and go to SETUP.
  - The cs check has priority over the addr check.
- SETUP: lasts 1 half-period with sclk low, then go to SHIFT_TX.
- SHIFT_TX: frame = op bit (1=write), then addr LSB-first, then (writes only) data LSB-first.
  - Bit count = 1+ADDR_W (read) or 1+ADDR_W+DATA_W (write).
  - Each bit occupies one sclk period: rise tick, then fall tick. The next bit is presented on the fall tick.
  - After the last fall tick: writes go to HOLD; reads go to WAIT_START with mosi=0.
- WAIT_START: sclk keeps toggling. miso is sampled on each rise.
  - A sampled 1 is the start bit: go to SHIFT_RX.
  - If TIMEOUT rises pass with no start bit, set code 11 and go to HOLD.
- SHIFT_RX: capture DATA_W bits LSB-first on the next DATA_W rises, then go to HOLD after the final fall.
- HOLD: lasts 1 half-period with sclk low. Then cs_n returns to all 1 and the state goes to RESP.
- RESP: rsp_valid=1, and rsp_err=(code!=00).
  - Outputs stay stable until rsp_valid&rsp_ready, then go to IDLE.
  - rsp_ready is ignored when rsp_valid=0.
- Back-to-back requests: at least one IDLE cycle occurs between transactions, and cs_n stays high for at least that cycle.
- Write latency from the accept edge to rsp_valid = 2 + CLK_DIV*(2+2*(1+ADDR_W+DATA_W)) clk. With defaults this is 74.
- Error latency (codes 01/10): rsp_valid is 2 cycles after accept. sclk and cs_n are never active.
- Read data bit i is the i-th bit sampled after the start bit.

Test Plan:
1. Defaults. Write cs=1, addr=0x05, din=0xA3. Expect cs_n=4'b1101 during the frame, 17 sclk rises, mosi bits 1,1,0,1,0,0,0,0,0,1,1,0,0,0,1,0,1. rsp_valid at 74 clk after accept, rsp_code=00.
2. Read cs=0, addr=0x1F. Slave model returns a start bit after 3 sclk periods, then 0x5C LSB-first. Expect rsp_dout=0x5C, rsp_err=0, cs_n[0] low throughout.
3. Read addr=0x20 -> rsp_code=01, rsp_err=1, 2 cycles after accept, no sclk edges. req_cs=5 with NUM_CS=4 (CSW=2 cannot encode this, so rerun with NUM_CS=3): req_cs=3 -> code 10.
4. Read with miso held 0 -> after 64 sclk rises, rsp_code=11, rsp_dout=0, cs_n all high.
5. Hold rsp_ready=0 for 10 cycles -> rsp_valid and data stay stable, req_ready=0. Assert rsp_ready -> IDLE next cycle, and a queued request is accepted the cycle after.
6. Assert rst at the 8th sclk rise of a write -> next cycle cs_n all 1, sclk=0, no rsp_valid. A subsequent write completes normally.
